// File: rtl/data_mem_initiator.sv
// CPU-side load/store initiator for data_mem: validates, issues a one-cycle pulse, tracks clk_stall.
// Latency: illegal 1 cycle, hit STALL_GRACE+2, stalled one cycle after clk_stall falls; busy stalls the pipeline meanwhile.
module data_mem_initiator #(
  parameter int MAX_WAIT    = 64,
  parameter int STALL_GRACE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          stall_seen;
  logic          is_write;
  logic [3:0]    mask_dec;
  logic          legal;

  // Width and signedness from funct3; legality folds in encoding and alignment.
  always_comb begin
    mask_dec = 4'b0000;
    legal    = 1'b0;
    case (req_funct3)
      3'b000: begin mask_dec = {!req_write, 3'b001}; legal = 1'b1; end
      3'b001: begin mask_dec = {!req_write, 3'b011}; legal = !req_addr[0]; end
      3'b010: begin mask_dec = 4'b0111; legal = (req_addr[1:0] == 2'b00); end
      3'b100: begin mask_dec = 4'b0001; legal = !req_write; end
      3'b101: begin mask_dec = 4'b0011; legal = !req_write && !req_addr[0]; end
      default: begin mask_dec = 4'b0000; legal = 1'b0; end
    endcase
  end

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign rsp_valid    = (state == DONE);
  assign mem_memread  = (state == ISSUE) && !is_write;
  assign mem_memwrite = (state == ISSUE) && is_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      stall_seen     <= 1'b0;
      is_write       <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_rdata <= '0;
            if (legal) begin
              mem_addr       <= req_addr;
              mem_write_data <= req_wdata;
              mem_sign_mask  <= mask_dec;
              is_write       <= req_write;
              rsp_err        <= 1'b0;
              state          <= ISSUE;
            end else begin
              rsp_err <= 1'b1;
              state   <= DONE;
            end
          end
        end
        ISSUE: begin
          wait_cnt   <= '0;
          stall_seen <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mem_clk_stall)
            stall_seen <= 1'b1;
          // A stall that ended, or no stall at all within the grace window, both complete the access.
          if (!mem_clk_stall && (stall_seen || wait_cnt == CW'(STALL_GRACE - 1))) begin
            rsp_rdata <= is_write ? 32'h0 : mem_read_data;
            state     <= DONE;
          end else if (mem_clk_stall && wait_cnt == CW'(MAX_WAIT - 1)) begin
            rsp_err <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator with a small clk_stall responder standing in for data_mem.
module tb_data_mem_initiator;

  localparam int MAX_WAIT    = 64;
  localparam int STALL_GRACE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'h0;
  logic        mem_clk_stall = 1'b0;

  int errors = 0;
  int checks = 0;

  int stall_len  = 0;
  int stall_left = 0;
  logic stall_hold = 1'b0;
  int rd_cnt = 0, wr_cnt = 0, vld_cnt = 0;

  data_mem_initiator #(.MAX_WAIT(MAX_WAIT), .STALL_GRACE(STALL_GRACE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  // data_mem stand-in: raises clk_stall with the access pulse and holds it stall_len cycles.
  always @(posedge clk) begin
    #1;
    if (mem_memread || mem_memwrite) stall_left = stall_len;
    else if (stall_left > 0) stall_left = stall_left - 1;
    mem_clk_stall = (stall_left > 0) || stall_hold;
  end

  always @(negedge clk) begin
    if (mem_memread)  rd_cnt++;
    if (mem_memwrite) wr_cnt++;
    if (rsp_valid)    vld_cnt++;
  end

  // Issues one request and returns latency (edges from acceptance to rsp_valid, +1) or -1 on no response.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdat,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic [3:0] mask, output logic [31:0] wd, output logic stable);
    int k;
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    rd_cnt = 0; wr_cnt = 0;
    mem_read_data = rdat;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mask = mem_sign_mask; wd = mem_write_data;
    stable = 1'b1; k = 0;
    while (!rsp_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (mem_addr !== addr) stable = 1'b0;
    end
    lat = rsp_valid ? k + 1 : -1;
    rdata = rsp_rdata; err = rsp_err;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_err, mem_memread, mem_memwrite} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 100000",
                         {req_ready, busy, rsp_valid, rsp_err, mem_memread, mem_memwrite});
    end
    checks++;
    if ({mem_addr, mem_write_data, rsp_rdata, mem_sign_mask} !== 100'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wd=%h rd=%h mask=%b want all 0",
                         mem_addr, mem_write_data, rsp_rdata, mem_sign_mask);
    end
  endtask

  task automatic test_store_byte();
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    stall_len = 4;
    do_req(1'b1, 3'b000, 32'h400, 32'h0000_0AAA, 32'h0, lat, rd, err, m, wd, st);
    checks++; if (lat !== 6) begin errors++; $display("FAIL sb_latency: got %0d want 6", lat); end
    checks++; if (m !== 4'b0001) begin errors++; $display("FAIL sb_mask: got %b want 0001", m); end
    checks++; if (wd !== 32'h0000_0AAA) begin errors++; $display("FAIL sb_wdata: got %h want 00000aaa", wd); end
    checks++; if (wr_cnt !== 1 || rd_cnt !== 0) begin
      errors++; $display("FAIL sb_pulse: wr=%0d rd=%0d want 1 0", wr_cnt, rd_cnt); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL sb_addr_stable: got %b want 1", st); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL sb_rsp: err=%b rdata=%h want 0 0", err, rd); end
  endtask

  task automatic test_load_byte();
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    stall_len = 3;
    do_req(1'b0, 3'b000, 32'h400, 32'h0, 32'hFFFF_FFAA, lat, rd, err, m, wd, st);
    checks++; if (m !== 4'b1001) begin errors++; $display("FAIL lb_mask: got %b want 1001", m); end
    checks++; if (rd !== 32'hFFFF_FFAA || err !== 1'b0) begin
      errors++; $display("FAIL lb_rdata: got %h err=%b want ffffffaa 0", rd, err); end
    checks++; if (lat !== 5 || rd_cnt !== 1) begin
      errors++; $display("FAIL lb_latency: got %0d rd=%0d want 5 1", lat, rd_cnt); end
    do_req(1'b0, 3'b100, 32'h400, 32'h0, 32'h0000_00AA, lat, rd, err, m, wd, st);
    checks++; if (m !== 4'b0001) begin errors++; $display("FAIL lbu_mask: got %b want 0001", m); end
    checks++; if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL lbu_rdata: got %h want 000000aa", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    stall_len = 3;
    do_req(1'b1, 3'b001, 32'h100, 32'h0002_AAAA, 32'h0, lat, rd, err, m, wd, st);
    checks++; if (m !== 4'b0011 || wd !== 32'h0002_AAAA) begin
      errors++; $display("FAIL sh_issue: mask=%b wdata=%h want 0011 0002aaaa", m, wd); end
    do_req(1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFF_AAAA, lat, rd, err, m, wd, st);
    checks++; if (m !== 4'b1011 || rd !== 32'hFFFF_AAAA) begin
      errors++; $display("FAIL lh: mask=%b rdata=%h want 1011 ffffaaaa", m, rd); end
    do_req(1'b0, 3'b101, 32'h100, 32'h0, 32'h0000_AAAA, lat, rd, err, m, wd, st);
    checks++; if (m !== 4'b0011 || rd !== 32'h0000_AAAA) begin
      errors++; $display("FAIL lhu: mask=%b rdata=%h want 0011 0000aaaa", m, rd); end
  endtask

  task automatic test_word_hit();
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    stall_len = 0;
    do_req(1'b1, 3'b010, 32'h40, 32'hAAAA_AAAA, 32'h0, lat, rd, err, m, wd, st);
    checks++; if (m !== 4'b0111 || lat !== STALL_GRACE + 2) begin
      errors++; $display("FAIL sw_hit: mask=%b lat=%0d want 0111 %0d", m, lat, STALL_GRACE + 2); end
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAA_AAAA, lat, rd, err, m, wd, st);
    checks++; if (lat !== STALL_GRACE + 2) begin
      errors++; $display("FAIL lw_hit_latency: got %0d want %0d", lat, STALL_GRACE + 2); end
    checks++; if (m !== 4'b0111 || rd !== 32'hAAAA_AAAA || err !== 1'b0) begin
      errors++; $display("FAIL lw_hit_rsp: mask=%b rdata=%h err=%b want 0111 aaaaaaaa 0", m, rd, err); end
  endtask

  task automatic test_illegal();
    logic        wr_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_v [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ad_v [4] = '{32'h101, 32'h42, 32'h40, 32'h40};
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      do_req(wr_v[i], f3_v[i], ad_v[i], 32'h1234_5678, 32'hDEAD_BEEF, lat, rd, err, m, wd, st);
      checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || rd_cnt !== 0 || wr_cnt !== 0) begin
        errors++; $display("FAIL illegal_%0d: lat=%0d err=%b rdata=%h rd=%0d wr=%0d want 1 1 0 0 0",
                           i, lat, err, rd, rd_cnt, wr_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    stall_len = 0; stall_hold = 1'b1;
    do_req(1'b0, 3'b010, 32'h80, 32'h0, 32'h5555_5555, lat, rd, err, m, wd, st);
    stall_hold = 1'b0;
    checks++; if (lat !== MAX_WAIT + 2 || err !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL timeout: lat=%0d err=%b rdata=%h want %0d 1 0", lat, err, rd, MAX_WAIT + 2); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    stall_hold = 1'b1;
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'hC0;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || mem_addr !== 32'hC0) begin
      errors++; $display("FAIL rst_pre: busy=%b addr=%h want 1 000000c0", busy, mem_addr); end
    @(negedge clk); rst = 1'b1; vld_cnt = 0; #1;
    checks++;
    if ({req_ready, busy, rsp_valid, mem_memread, mem_memwrite} !== 5'b10000 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mid_wait: ctl=%b addr=%h want 10000 0",
                         {req_ready, busy, rsp_valid, mem_memread, mem_memwrite}, mem_addr);
    end
    stall_hold = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (vld_cnt !== 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_rsp: rsp_valid pulses=%0d ready=%b want 0 1", vld_cnt, req_ready); end
    stall_len = 0;
    do_req(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BAD_F00D, lat, rd, err, m, wd, st);
    checks++; if (lat !== STALL_GRACE + 2 || rd !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rst_recover: lat=%0d rdata=%h want %0d 0badf00d", lat, rd, STALL_GRACE + 2); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, wd; logic err, st; logic [3:0] m;
    stall_len = 0;
    do_req(1'b0, 3'b010, 32'h200, 32'h0, 32'h1111_1111, lat, rd, err, m, wd, st);
    // In DONE now; present the next request immediately and keep it up.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h301;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL b2b_ignored: ready=%b addr=%h want 1 00000200", req_ready, mem_addr); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || mem_addr !== 32'h301 || mem_sign_mask !== 4'b1001) begin
      errors++; $display("FAIL b2b_accept: busy=%b addr=%h mask=%b want 1 00000301 1001",
                         busy, mem_addr, mem_sign_mask);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_done: ready=%b want 1", req_ready); end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_store_byte();
    test_load_byte();
    test_half();
    test_word_hit();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_initiator.md
Name: data_mem_initiator

Overview:
- Load/store initiator: the CPU-side end of the data_mem port.
- Accepts one load or store request at a time from the pipeline, using RISC-V funct3 encoding.
- Checks alignment and encoding, issues a one-cycle memread/memwrite pulse to data_mem and follows data_mem's clk_stall until the access completes.
- Returns the read data or an error, and stalls the pipeline for the whole access.

Parameters:
- MAX_WAIT, 64: maximum cycles in WAIT before the access is aborted with an error.
- STALL_GRACE, 2: cycles after issue with clk_stall never seen high that count as a single-cycle hit.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; valid while rsp_valid = 1, 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: access misaligned, illegal funct3, or timed out.
- busy  out  1  pipeline stall; high from the cycle after acceptance through DONE.
- mem_addr  out  32  to data_mem addr.
- mem_write_data  out  32  to data_mem write_data.
- mem_memwrite  out  1  to data_mem memwrite.
- mem_memread  out  1  to data_mem memread.
- mem_sign_mask  out  4  to data_mem sign_mask.
- mem_read_data  in  32  from data_mem read_data; already extended by data_mem.
- mem_clk_stall  in  1  from data_mem clk_stall.

Behaviour:
- Reset (asynchronous, rst high) forces:
  - state IDLE;
  - all outputs 0, except req_ready = 1;
  - wait counter 0 and the stall-seen flag cleared.
- Reset during ISSUE or WAIT abandons the access: no rsp_valid is produced and mem_memread/mem_memwrite drop immediately.
- sign_mask encoding:
  - bits[2:0]: 001 byte, 011 half, 111 word.
  - bit3: 1 = signed load; 0 for unsigned loads and for all stores.
  - Mapping: LB = 1001, LBU = 0001, LH = 1011, LHU = 0011, LW = 0111, SB = 0001, SH = 0011, SW = 0111.
- Legality on acceptance:
  - Illegal loads: funct3 011, 110, 111. Illegal stores: funct3 other than 000/001/010.
  - Misaligned: half with addr[0] = 1; word with addr[1:0] ≠ 00.
- State machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
  - IDLE, request accepted and illegal: next state DONE with rsp_err = 1. No memread/memwrite is ever driven.
  - IDLE, request accepted and legal: latch mem_addr, mem_write_data (req_wdata unmodified) and mem_sign_mask; next state ISSUE.
  - ISSUE (exactly 1 cycle): mem_memread = !req_write, mem_memwrite = req_write. Next state WAIT with counter = 0.
  - WAIT: mem_memread = mem_memwrite = 0; counter increments every cycle; stall_seen is set when mem_clk_stall = 1.
    - stall_seen & !mem_clk_stall -> DONE; capture mem_read_data for loads.
    - !stall_seen & counter == STALL_GRACE-1 & !mem_clk_stall -> DONE with capture (hit path).
    - counter == MAX_WAIT-1 while stalled -> DONE with rsp_err = 1.
  - DONE (1 cycle): rsp_valid = 1; next state IDLE.
- mem_addr, mem_write_data and mem_sign_mask hold stable from ISSUE through DONE and keep their values in IDLE; they change only on the next acceptance.
- All outputs are registered or decoded from state; there is no combinational path from mem_clk_stall to busy.
- Latency, acceptance at edge N:
  - hit: rsp_valid at N+1+STALL_GRACE+1;
  - stall of k cycles: rsp_valid one cycle after clk_stall falls;
  - illegal: rsp_valid at N+1.
- req_valid is ignored outside IDLE; back-to-back requests are accepted in the IDLE cycle following DONE.

Test Plan:
- SB addr 0x400 wdata 0x00000AAA, data_mem stalls 4 cycles -> one-cycle mem_memwrite, sign_mask 0001, mem_addr 0x400 stable through DONE; rsp_valid, rsp_err = 0.
- LB then LBU at 0x400 with data_mem returning 0xFFFFFFAA / 0x000000AA -> sign_mask 1001 then 0011? no: 1001 then 0001; rsp_rdata equals the returned values.
- SH 0x100 wdata 0x2AAAA, then LH and LHU -> sign_mask 0011, 1011, 0011; LH rsp_rdata 0xFFFFAAAA.
- SW 0x40 0xAAAAAAAA, then LW with clk_stall never asserted -> sign_mask 0111; LW rsp_valid exactly STALL_GRACE+2 cycles after acceptance.
- LH at 0x101, LW at 0x42, funct3 011 load -> rsp_err pulse one cycle after acceptance; mem_memread never high.
- clk_stall held high -> rsp_err after MAX_WAIT cycles; separately, rst asserted mid-WAIT -> outputs at reset values at once, no rsp_valid, req_ready = 1.
